seq_timing_unit: RTL and testbench

//   Instruction-cycle timing generator for the basic computer. Holds the start/stop flip-flop S,
//   the sequence counter SC and the instruction register IR. Produces the one-hot timing vector
//   T[7:0], the opcode decode D[7:0] and the indirect bit I. The common-bus control logic uses

---
 rtl/seq_timing_unit.sv | 97 +++++++++
 tb/tb_seq_timing_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_timing_unit.sv
// -----------------------------------------------------------------------------
// seq_timing_unit
//   Instruction-cycle timing generator for the basic computer. Holds the
//   start/stop flip-flop S, the sequence counter SC and the instruction
//   register IR. Produces the one-hot timing vector T, the one-hot opcode
//   decode D and the indirect bit I for the common-bus control logic.
//
//   Ports
//     clk      in   1         rising-edge clock
//     rst_n    in   1         synchronous reset, active low
//     start    in   1         set S (begin/resume execution)
//     halt     in   1         clear S and SC (HLT or external stop)
//     sc_clr   in   1         instruction complete: SC returns to 0
//     bus_in   in   WORD_W    common-bus value, loaded into IR at T2
//     T        out  T_STATES  one-hot timing, all-zero while stopped
//     D        out  8         one-hot decode of the IR opcode field
//     I        out  1         IR[WORD_W-1]
//     ir_out   out  WORD_W    current IR contents
//     running  out  1         S flip-flop
//     seq_err  out  1         sticky: SC wrapped without sc_clr
// -----------------------------------------------------------------------------
module seq_timing_unit #(
  parameter int unsigned T_STATES = 8,
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned OPC_LSB  = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                halt,
  input  logic                sc_clr,
  input  logic [WORD_W-1:0]   bus_in,
  output logic [T_STATES-1:0] T,
  output logic [7:0]          D,
  output logic                I,
  output logic [WORD_W-1:0]   ir_out,
  output logic                running,
  output logic                seq_err
);

  localparam int unsigned SC_W = $clog2(T_STATES);
  localparam logic [SC_W-1:0] SC_LAST  = SC_W'(T_STATES - 1);
  localparam logic [SC_W-1:0] SC_FETCH = SC_W'(2);

  logic              s_ff;
  logic [SC_W-1:0]   sc;
  logic [WORD_W-1:0] ir;
  logic              err_ff;

  // State registers. halt clears SC regardless of S so that any restart
  // begins at T0; when halt is present the normal SC advance is skipped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ff   <= 1'b0;
      sc     <= '0;
      ir     <= '0;
      err_ff <= 1'b0;
    end else begin
      if (halt)
        s_ff <= 1'b0;
      else if (start)
        s_ff <= 1'b1;

      if (halt) begin
        sc <= '0;
      end else if (s_ff) begin
        if (sc_clr) begin
          sc <= '0;
        end else if (sc == SC_LAST) begin
          sc     <= '0;
          err_ff <= 1'b1;
        end else begin
          sc <= sc + SC_W'(1);
        end
      end

      // IR captures the bus at the end of T2, so D and I are valid from T3.
      if (s_ff && (sc == SC_FETCH))
        ir <= bus_in;
    end
  end

  // Timing and decode outputs are purely combinational from the registers.
  always_comb begin
    T = '0;
    if (s_ff)
      T[sc] = 1'b1;
    D = '0;
    D[ir[OPC_LSB +: 3]] = 1'b1;
  end

  assign I       = ir[WORD_W-1];
  assign ir_out  = ir;
  assign running = s_ff;
  assign seq_err = err_ff;

endmodule

// File: tb/tb_seq_timing_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_timing_unit
//   Self-checking bench for seq_timing_unit. A behavioural model (running
//   flag, integer step count, IR word, sticky error) advances with every
//   clock edge; directed scenarios check constants and the random scenario
//   checks every output against the model each cycle.
// -----------------------------------------------------------------------------
module tb_seq_timing_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        sc_clr = 1'b0;
  logic [15:0] bus_in = '0;
  logic [7:0]  T;
  logic [7:0]  D;
  logic        I;
  logic [15:0] ir_out;
  logic        running;
  logic        seq_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit        m_run = 1'b0;
  int        m_step = 0;
  bit [15:0] m_ir = '0;
  bit        m_err = 1'b0;

  seq_timing_unit #(.T_STATES(8), .WORD_W(16), .OPC_LSB(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .sc_clr(sc_clr),
    .bus_in(bus_in), .T(T), .D(D), .I(I), .ir_out(ir_out),
    .running(running), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge from the current input values.
  task automatic model_edge();
    bit was_run;
    int was_step;
    was_run  = m_run;
    was_step = m_step;
    if (!rst_n) begin
      m_run = 0; m_step = 0; m_ir = '0; m_err = 0;
    end else begin
      if (was_run && was_step == 2) m_ir = bus_in;
      if (halt) m_run = 0;
      else if (start) m_run = 1;
      if (halt) m_step = 0;
      else if (was_run) begin
        if (sc_clr) m_step = 0;
        else begin
          if (was_step + 1 == 8) m_err = 1;
          m_step = (was_step + 1) % 8;
        end
      end
    end
  endtask

  // One clock edge: DUT and model both see the same inputs, outputs settle.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(); cycle();
    checks += 6;
    if (T !== 8'h00) begin errors++; $display("[TB] FAIL reset_T got=%h exp=00", T); end
    if (D !== 8'h01) begin errors++; $display("[TB] FAIL reset_D got=%h exp=01", D); end
    if (I !== 1'b0) begin errors++; $display("[TB] FAIL reset_I got=%b exp=0", I); end
    if (ir_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_ir got=%h exp=0000", ir_out); end
    if (running !== 1'b0) begin errors++; $display("[TB] FAIL reset_running got=%b exp=0", running); end
    if (seq_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_seq_err got=%b exp=0", seq_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    bus_in = 16'h9123;
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks += 2;
    if (running !== 1'b1) begin errors++; $display("[TB] FAIL fetch_running got=%b exp=1", running); end
    if (T !== 8'h01) begin errors++; $display("[TB] FAIL fetch_T0 got=%h exp=01", T); end
    cycle();
    checks++;
    if (T !== 8'h02) begin errors++; $display("[TB] FAIL fetch_T1 got=%h exp=02", T); end
    cycle();
    checks++;
    if (T !== 8'h04) begin errors++; $display("[TB] FAIL fetch_T2 got=%h exp=04", T); end
    cycle();
    checks += 4;
    if (T !== 8'h08) begin errors++; $display("[TB] FAIL fetch_T3 got=%h exp=08", T); end
    if (ir_out !== 16'h9123) begin errors++; $display("[TB] FAIL fetch_ir got=%h exp=9123", ir_out); end
    if (D !== 8'h02) begin errors++; $display("[TB] FAIL fetch_D got=%h exp=02", D); end
    if (I !== 1'b1) begin errors++; $display("[TB] FAIL fetch_I got=%b exp=1", I); end
  endtask

  // Enters at T3; start while running must not disturb SC.
  task automatic test_sc_clr();
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if (T !== 8'h10) begin errors++; $display("[TB] FAIL start_ignored_T got=%h exp=10", T); end
    cycle();
    sc_clr = 1'b1;
    cycle();
    sc_clr = 1'b0;
    checks += 2;
    if (T !== 8'h01) begin errors++; $display("[TB] FAIL sc_clr_T got=%h exp=01", T); end
    if (seq_err !== 1'b0) begin errors++; $display("[TB] FAIL sc_clr_seq_err got=%b exp=0", seq_err); end
  endtask

  // Enters at T0 with no sc_clr pending.
  task automatic test_wrap();
    for (int i = 0; i < 7; i++) cycle();
    checks += 2;
    if (T !== 8'h80) begin errors++; $display("[TB] FAIL wrap_T7 got=%h exp=80", T); end
    if (seq_err !== 1'b0) begin errors++; $display("[TB] FAIL wrap_pre_err got=%b exp=0", seq_err); end
    cycle();
    checks += 2;
    if (T !== 8'h01) begin errors++; $display("[TB] FAIL wrap_T0 got=%h exp=01", T); end
    if (seq_err !== 1'b1) begin errors++; $display("[TB] FAIL wrap_err got=%b exp=1", seq_err); end
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (seq_err !== 1'b1) begin errors++; $display("[TB] FAIL wrap_err_sticky got=%b exp=1", seq_err); end
  endtask

  // Enters at T3 (IR holds 9123); halt at T4, sc_clr while stopped is inert.
  task automatic test_halt();
    logic [15:0] saved_ir;
    cycle();
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    saved_ir = ir_out;
    checks += 2;
    if (T !== 8'h00) begin errors++; $display("[TB] FAIL halt_T got=%h exp=00", T); end
    if (running !== 1'b0) begin errors++; $display("[TB] FAIL halt_running got=%b exp=0", running); end
    bus_in = 16'h4ABC;
    sc_clr = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    sc_clr = 1'b0;
    checks += 2;
    if (T !== 8'h00) begin errors++; $display("[TB] FAIL idle_T got=%h exp=00", T); end
    if (ir_out !== 16'h9123) begin errors++; $display("[TB] FAIL idle_ir got=%h exp=9123", ir_out); end
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks += 2;
    if (T !== 8'h01) begin errors++; $display("[TB] FAIL resume_T got=%h exp=01", T); end
    if (ir_out !== saved_ir) begin errors++; $display("[TB] FAIL resume_ir got=%h exp=%h", ir_out, saved_ir); end
  endtask

  // Enters at T0 running.
  task automatic test_start_halt();
    start = 1'b1;
    halt = 1'b1;
    cycle();
    start = 1'b0;
    halt = 1'b0;
    checks += 2;
    if (running !== 1'b0) begin errors++; $display("[TB] FAIL both_running got=%b exp=0", running); end
    if (T !== 8'h00) begin errors++; $display("[TB] FAIL both_T got=%h exp=00", T); end
    bus_in = 16'h5ABC;
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle(); cycle(); cycle();
    checks += 3;
    if (T !== 8'h08) begin errors++; $display("[TB] FAIL midreset_pre_T got=%h exp=08", T); end
    if (ir_out !== 16'h5ABC) begin errors++; $display("[TB] FAIL midreset_pre_ir got=%h exp=5abc", ir_out); end
    if (D !== 8'h20) begin errors++; $display("[TB] FAIL midreset_pre_D got=%h exp=20", D); end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    checks += 4;
    if (ir_out !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_ir got=%h exp=0000", ir_out); end
    if (T !== 8'h00) begin errors++; $display("[TB] FAIL midreset_T got=%h exp=00", T); end
    if (seq_err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_err got=%b exp=0", seq_err); end
    if (running !== 1'b0) begin errors++; $display("[TB] FAIL midreset_running got=%b exp=0", running); end
  endtask

  // Random control and bus traffic compared against the model every cycle.
  // halt is withheld on the wrap cycle, where halt and wrap would coincide.
  task automatic test_random();
    logic [7:0] exp_t;
    logic [7:0] exp_d;
    for (int n = 0; n < 400; n++) begin
      rst_n  = ($urandom_range(0, 59) != 0);
      start  = ($urandom_range(0, 7) == 0);
      halt   = ($urandom_range(0, 19) == 0) && !(m_run && m_step == 7);
      sc_clr = ($urandom_range(0, 9) == 0);
      bus_in = 16'($urandom);
      cycle();
      exp_t = m_run ? 8'(1 << m_step) : 8'h00;
      exp_d = 8'(1 << int'(m_ir[14:12]));
      checks += 6;
      if (T !== exp_t) begin errors++; $display("[TB] FAIL rand_T n=%0d got=%h exp=%h", n, T, exp_t); end
      if (D !== exp_d) begin errors++; $display("[TB] FAIL rand_D n=%0d got=%h exp=%h", n, D, exp_d); end
      if (I !== m_ir[15]) begin errors++; $display("[TB] FAIL rand_I n=%0d got=%b exp=%b", n, I, m_ir[15]); end
      if (ir_out !== m_ir) begin errors++; $display("[TB] FAIL rand_ir n=%0d got=%h exp=%h", n, ir_out, m_ir); end
      if (running !== m_run) begin errors++; $display("[TB] FAIL rand_running n=%0d got=%b exp=%b", n, running, m_run); end
      if (seq_err !== m_err) begin errors++; $display("[TB] FAIL rand_seq_err n=%0d got=%b exp=%b", n, seq_err, m_err); end
    end
    rst_n = 1'b1; start = 1'b0; halt = 1'b0; sc_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_sc_clr();
    test_wrap();
    test_halt();
    test_start_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
